clic_vector: RTL and testbench

Fetches the handler address for a selective-hardware-vectored CLIC interrupt. It sits directly downstream of the CLIC controller and consumes `clic_meip`/`clic_meid`. When the core takes the trap and requests a vector, the block reads word `meid` of the vector table at `mtvt` over the shared memory bus. It then returns the handler address to the core with a hold-until-ack handshake.

---
 rtl/clic_vector.sv | 183 ++++++++++++++++++
 tb/tb_clic_vector.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clic_vector.sv
// clic_vector: fetches the handler address for a selective-hardware-vectored
// CLIC interrupt by reading word clic_meid of the vector table at mtvt over
// the shared memory bus, then presents it to the core until acknowledged.
// Optional feature macro: CLIC_VECTOR_TIMEOUT_EN bounds WAIT/DRAIN by
// timeout_cycles and reports an abandoned fetch through vec_error.
`timescale 1ns/1ps
module clic_vector #(
  parameter int unsigned timeout_cycles = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clic_meip,
  input  logic [11:0] clic_meid,
  input  logic [31:0] mtvt,
  input  logic        vec_req,
  input  logic        vec_kill,
  input  logic        vec_ack,
  output logic        vec_valid,
  output logic [31:0] vec_addr,
  output logic [11:0] vec_id,
  output logic        vec_error,
  output logic        vec_busy,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_vec_addr;
  logic [11:0] r_vec_id;
  logic [31:0] r_mem_addr;
  logic [31:0] w_fetch_addr;
  logic        w_accept;
  logic        w_unused;

  generate
    if (timeout_cycles < 1 || timeout_cycles > 255) begin : g_bad_timeout
      $error("clic_vector: timeout_cycles must be within 1..255");
    end
  endgenerate

  // Table base is 64-byte aligned; each entry is one 32-bit word.
  assign w_fetch_addr = {mtvt[31:6], 6'b0} + {18'b0, clic_meid, 2'b00};
  assign w_accept     = vec_req && clic_meip && !vec_kill;
  assign w_unused     = ^{mtvt[5:0], mem_rdata[0]};

  assign vec_valid = (r_state == S_DONE);
  assign vec_busy  = (r_state != S_IDLE);
  assign mem_valid = (r_state == S_ISSUE);
  assign vec_addr  = r_vec_addr;
  assign vec_id    = r_vec_id;
  assign mem_addr  = r_mem_addr;
  assign mem_instr = 1'b0;
  assign mem_wdata = '0;
  assign mem_wstrb = '0;

`ifdef CLIC_VECTOR_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(timeout_cycles - 32'd1);

  logic [7:0] r_cnt;
  logic       r_vec_error;

  assign vec_error = r_vec_error;

  // Fetch sequencer with bounded WAIT/DRAIN.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_vec_addr  <= '0;
      r_vec_id    <= '0;
      r_mem_addr  <= '0;
      r_cnt       <= '0;
      r_vec_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_vec_id   <= clic_meid;
            r_mem_addr <= w_fetch_addr;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_ready) begin
            if (vec_kill) begin
              r_state <= S_IDLE;
            end else begin
              r_vec_addr  <= {mem_rdata[31:1], 1'b0};
              r_vec_error <= 1'b0;
              r_state     <= S_DONE;
            end
          end else if (vec_kill) begin
            r_cnt   <= '0;
            r_state <= S_DRAIN;
          end else if (r_cnt == TMO_LAST) begin
            r_vec_addr  <= '0;
            r_vec_error <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DRAIN: begin
          if (mem_ready || r_cnt == TMO_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          if (vec_ack || vec_kill) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign vec_error = 1'b0;

  // Fetch sequencer; WAIT/DRAIN wait for the bus indefinitely.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_vec_addr <= '0;
      r_vec_id   <= '0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_vec_id   <= clic_meid;
            r_mem_addr <= w_fetch_addr;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (mem_ready) begin
            if (vec_kill) begin
              r_state <= S_IDLE;
            end else begin
              r_vec_addr <= {mem_rdata[31:1], 1'b0};
              r_state    <= S_DONE;
            end
          end else if (vec_kill) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mem_ready) begin
            r_state <= S_IDLE;
          end
        end
        S_DONE: begin
          if (vec_ack || vec_kill) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_clic_vector.sv
// Self-checking bench for clic_vector: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level model of the fetch.
`timescale 1ns/1ps
module tb_clic_vector;

  localparam int unsigned TMO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        clic_meip;
  logic [11:0] clic_meid;
  logic [31:0] mtvt;
  logic        vec_req, vec_kill, vec_ack;
  logic        vec_valid, vec_error, vec_busy;
  logic [31:0] vec_addr;
  logic [11:0] vec_id;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int mv_count = 0;
  bit seen_valid = 1'b0;

  clic_vector #(.timeout_cycles(TMO)) dut (
    .clock(clock), .reset(reset), .clic_meip(clic_meip), .clic_meid(clic_meid),
    .mtvt(mtvt), .vec_req(vec_req), .vec_kill(vec_kill), .vec_ack(vec_ack),
    .vec_valid(vec_valid), .vec_addr(vec_addr), .vec_id(vec_id),
    .vec_error(vec_error), .vec_busy(vec_busy), .mem_valid(mem_valid),
    .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_pend, m_out, m_killed, m_res, m_rerr;
  logic [31:0] m_maddr, m_raddr;
  logic [11:0] m_id;
  int          m_cnt;

  always @(posedge clock) begin
    if (reset) begin
      m_pend = 0; m_out = 0; m_killed = 0; m_res = 0; m_rerr = 0;
      m_maddr = '0; m_raddr = '0; m_id = '0; m_cnt = 0;
    end else if (m_res) begin
      if (vec_ack || vec_kill) m_res = 0;
    end else if (m_out) begin
      if (mem_ready) begin
        m_out = 0;
        if (!m_killed && !vec_kill) begin
          m_res = 1; m_raddr = {mem_rdata[31:1], 1'b0}; m_rerr = 0;
        end
        m_killed = 0;
      end else if (vec_kill && !m_killed) begin
        m_killed = 1; m_cnt = 0;
      end else begin
`ifdef CLIC_VECTOR_TIMEOUT_EN
        m_cnt++;
        if (m_cnt == int'(TMO)) begin
          m_out = 0;
          if (!m_killed) begin m_res = 1; m_raddr = '0; m_rerr = 1; end
          m_killed = 0;
        end
`endif
      end
    end else if (m_pend) begin
      m_pend = 0; m_out = 1; m_killed = 0; m_cnt = 0;
    end else if (vec_req && clic_meip && !vec_kill) begin
      m_pend  = 1;
      m_id    = clic_meid;
      m_maddr = (mtvt & 32'hFFFF_FFC0) + ({20'b0, clic_meid} * 32'd4);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (vec_valid) seen_valid = 1'b1;
    if (mem_valid) mv_count++;
    chk("vec_valid", {31'b0, vec_valid}, {31'b0, m_res});
    chk("vec_busy",  {31'b0, vec_busy},  {31'b0, (m_pend | m_out | m_res)});
    chk("mem_valid", {31'b0, mem_valid}, {31'b0, m_pend});
    chk("mem_addr",  mem_addr, m_maddr);
    chk("vec_id",    {20'b0, vec_id}, {20'b0, m_id});
    chk("mem_const", {mem_instr, mem_wstrb, mem_wdata[26:0]}, 32'h0);
    chk("mem_wdata", mem_wdata, 32'h0);
    if (m_res) begin
      chk("vec_addr",  vec_addr, m_raddr);
      chk("vec_error", {31'b0, vec_error}, {31'b0, m_rerr});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic [31:0] tv, input logic [11:0] id);
    mtvt = tv; clic_meid = id; clic_meip = 1'b1; vec_req = 1'b1;
    tick();
    vec_req = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    mem_ready = 1'b1; mem_rdata = d;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic ack();
    vec_ack = 1'b1;
    tick();
    vec_ack = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valid"}, {31'b0, vec_valid}, 32'h0);
    chk({nm, "_addr"},  vec_addr, 32'h0);
    chk({nm, "_id"},    {20'b0, vec_id}, 32'h0);
    chk({nm, "_err"},   {31'b0, vec_error}, 32'h0);
    chk({nm, "_busy"},  {31'b0, vec_busy}, 32'h0);
    chk({nm, "_mval"},  {31'b0, mem_valid}, 32'h0);
    chk({nm, "_maddr"}, mem_addr, 32'h0);
  endtask

  initial begin
    reset = 1'b1; clic_meip = 0; clic_meid = '0; mtvt = '0;
    vec_req = 0; vec_kill = 0; vec_ack = 0; mem_rdata = '0; mem_ready = 0;
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // Basic fetch
    start(32'h8000_0000, 12'd5);
    chk("basic_mval", {31'b0, mem_valid}, 32'h1);
    chk("basic_maddr", mem_addr, 32'h8000_0014);
    tick();
    chk("basic_mval_off", {31'b0, mem_valid}, 32'h0);
    respond(32'h8000_1235);
    chk("basic_valid", {31'b0, vec_valid}, 32'h1);
    chk("basic_addr", vec_addr, 32'h8000_1234);
    chk("basic_id", {20'b0, vec_id}, 32'h5);
    tick(); tick();
    chk("basic_hold", {31'b0, vec_valid}, 32'h1);
    chk("basic_hold_addr", vec_addr, 32'h8000_1234);
    ack();
    chk("basic_acked", {31'b0, vec_valid}, 32'h0);
    chk("basic_idle", {31'b0, vec_busy}, 32'h0);

    // Address arithmetic
    start(32'h8000_003F, 12'hFFF);
    chk("arith_max", mem_addr, 32'h8000_3FFC);
    tick(); respond(32'h1); ack();
    start(32'hFFFF_FFC0, 12'h010);
    chk("arith_wrap", mem_addr, 32'h0000_0000);
    tick(); respond(32'h2); ack();

    // Gating on clic_meip
    clic_meip = 1'b0; vec_req = 1'b1;
    tick();
    chk("gate_busy", {31'b0, vec_busy}, 32'h0);
    chk("gate_mval", {31'b0, mem_valid}, 32'h0);
    tick();
    chk("gate_busy2", {31'b0, vec_busy}, 32'h0);
    vec_req = 1'b0;

    // Second request during WAIT is ignored
    mv_count = 0;
    start(32'h0000_1000, 12'd9);
    tick();
    vec_req = 1'b1; tick(); tick(); vec_req = 1'b0;
    respond(32'h0000_4444);
    chk("dup_addr", vec_addr, 32'h0000_4444);
    ack();
    tick();
    chk("dup_one_mval", mv_count, 32'd1);

    // Kill in WAIT, response three cycles later
    start(32'h0000_2000, 12'd2);
    tick();
    seen_valid = 1'b0;
    vec_kill = 1'b1; tick(); vec_kill = 1'b0;
    chk("kill_drain_busy", {31'b0, vec_busy}, 32'h1);
    tick(); tick();
    respond(32'hDEAD_BEEF);
    chk("kill_idle", {31'b0, vec_busy}, 32'h0);
    chk("kill_no_valid", {31'b0, seen_valid}, 32'h0);
    start(32'h0000_1000, 12'd3);
    chk("kill_next_maddr", mem_addr, 32'h0000_100C);
    tick();
    respond(32'h0000_0055);
    chk("kill_next_valid", {31'b0, vec_valid}, 32'h1);
    chk("kill_next_addr", vec_addr, 32'h0000_0054);
    ack();

    // Reset mid-WAIT
    start(32'h8000_0000, 12'd7);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk_all_zero("rstmid");
    respond(32'h0000_ABCD);
    chk("rstmid_late_busy", {31'b0, vec_busy}, 32'h0);
    chk("rstmid_late_valid", {31'b0, vec_valid}, 32'h0);

    // Timeout behaviour
    start(32'h0000_3000, 12'd1);
    tick();
`ifdef CLIC_VECTOR_TIMEOUT_EN
    repeat (3) tick();
    chk("tmo_not_yet", {31'b0, vec_valid}, 32'h0);
    tick();
    chk("tmo_valid", {31'b0, vec_valid}, 32'h1);
    chk("tmo_err", {31'b0, vec_error}, 32'h1);
    chk("tmo_addr", vec_addr, 32'h0);
    respond(32'h0000_1234);
    chk("tmo_late_valid", {31'b0, vec_valid}, 32'h1);
    chk("tmo_late_addr", vec_addr, 32'h0);
    ack();
`else
    repeat (10) tick();
    chk("notmo_busy", {31'b0, vec_busy}, 32'h1);
    chk("notmo_valid", {31'b0, vec_valid}, 32'h0);
    respond(32'h0000_2001);
    chk("notmo_addr", vec_addr, 32'h0000_2000);
    chk("notmo_err", {31'b0, vec_error}, 32'h0);
    ack();
`endif

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      clic_meip = ($urandom_range(0, 3) != 0);
      clic_meid = 12'($urandom);
      mtvt      = $urandom;
      vec_req   = ($urandom_range(0, 9) < 3);
      vec_kill  = ($urandom_range(0, 19) == 0);
      vec_ack   = ($urandom_range(0, 9) < 3);
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      tick();
    end

    reset = 0; vec_req = 0; vec_kill = 0; vec_ack = 0; mem_ready = 0;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
